// File: rtl/pe_task_scheduler.sv
// pe_task_scheduler: round-robin front end that time-shares one pe_core
// between NUM_REQ command sources. Each command is issued with a start pulse
// and watched by a cycle budget. A tagged response goes back before the next
// command is granted.
module pe_task_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_W       = 2,
  parameter int INSTR_W        = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  output logic                       pe_start,
  output logic [INSTR_W-1:0]         pe_instr,
  input  logic                       pe_done,
  output logic                       pe_abort,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [REQ_ID_W-1:0]        resp_id,
  output logic [1:0]                 resp_status,
  output logic                       busy,
  output logic [15:0]                done_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ILLEGAL = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  state_t               state_q, state_d;
  logic [REQ_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_W-1:0]  id_q, id_d;
  logic [1:0]           status_q, status_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [INSTR_W-1:0]   pe_instr_q, pe_instr_d;
  logic [15:0]          done_count_q, done_count_d;

  logic [INSTR_W-1:0]   instr_arr [NUM_REQ];
  logic                 grant_found;
  logic [REQ_ID_W-1:0]  grant_id;
  logic [REQ_ID_W-1:0]  scan_idx;
  logic [INSTR_W-1:0]   grant_instr;
  logic [3:0]           grant_op;
  logic                 grant_legal;
  logic                 timeout_hit;

  // Unpack the flattened instruction bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign instr_arr[gi] = req_instr[gi*INSTR_W +: INSTR_W];
    end
  endgenerate

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = REQ_ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign grant_instr = instr_arr[grant_id];
  assign grant_op    = grant_instr[INSTR_W-1 -: 4];
  assign grant_legal = (grant_op == 4'd1) || (grant_op == 4'd2) || (grant_op == 4'd3);
  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // State and datapath registers; reset drops any in-flight command silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      status_q     <= ST_OK;
      timer_q      <= '0;
      pe_instr_q   <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      status_q     <= status_d;
      timer_q      <= timer_d;
      pe_instr_q   <= pe_instr_d;
      done_count_q <= done_count_d;
    end
  end

  // Next-state logic: accept, issue, watch the budget, then hand back a response.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    status_d     = status_q;
    timer_d      = timer_q;
    pe_instr_d   = pe_instr_q;
    done_count_d = done_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          id_d = grant_id;
          if (grant_legal) begin
            pe_instr_d = grant_instr;
            state_d    = S_ISSUE;
          end else begin
            status_d = ST_ILLEGAL;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A completion on the last budget cycle still counts as a success.
        if (pe_done) begin
          status_d = ST_OK;
          state_d  = S_RESP;
          if (done_count_q != 16'hFFFF) begin
            done_count_d = done_count_q + 16'd1;
          end
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rr_ptr_d = REQ_ID_W'((int'(id_q) + 1) % NUM_REQ);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; the grant is masked while in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && !rst) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
    pe_start    = (state_q == S_ISSUE);
    pe_abort    = (state_q == S_WAIT) && !pe_done && timeout_hit;
    resp_valid  = (state_q == S_RESP);
    busy        = (state_q != S_IDLE);
    resp_id     = id_q;
    resp_status = status_q;
    pe_instr    = pe_instr_q;
    done_count  = done_count_q;
  end

endmodule

// File: tb/tb_pe_task_scheduler.sv
// Bench for pe_task_scheduler: directed scenarios followed by randomized
// commands. Expected values come from a requester-level model that tracks
// the round-robin pointer, the completion count and the command outcome.
module tb_pe_task_scheduler;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_instr;
  logic            pe_start;
  logic [IW-1:0]   pe_instr;
  logic            pe_done;
  logic            pe_abort;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [1:0]      resp_status;
  logic            busy;
  logic [15:0]     done_count;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Model state: next requester to favour, and expected OK completions.
  int rr_m  = 0;
  int cnt_m = 0;
  logic [IW-1:0] instr_m [N];
  int obs_log [$];
  bit stray_en = 1'b0;

  always #5 clk = ~clk;

  pe_task_scheduler #(
    .NUM_REQ(N), .REQ_ID_W(2), .INSTR_W(IW), .TIMEOUT_CYCLES(TO), .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .pe_start(pe_start), .pe_instr(pe_instr), .pe_done(pe_done), .pe_abort(pe_abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_status(resp_status), .busy(busy), .done_count(done_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_instrs();
    for (int i = 0; i < N; i++) req_instr[i*IW +: IW] = instr_m[i];
  endtask

  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == N'(1 << i)) return i;
    return -1;
  endfunction

  // One full command: called at a negedge in IDLE with req_valid/instr set.
  // done_lat = WAIT cycle (1-based) that carries pe_done, 0 = never.
  task automatic run_cmd(input string tag, input int done_lat, input int hold);
    int g;
    logic [IW-1:0] ins;
    bit legal;
    int exp_st;
    bit finished;
    g = model_grant(req_valid);
    ins = instr_m[g];
    legal = ins[31:28] inside {4'd1, 4'd2, 4'd3};
    #1;
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " req_ready"}, 32'(req_ready), 32'(1 << g));
    obs_log.push_back(onehot_idx(req_ready));
    @(negedge clk); #1;
    check({tag, " ready_after_accept"}, 32'(req_ready), 32'd0);
    if (legal) begin
      check({tag, " pe_start"}, 32'(pe_start), 32'd1);
      check({tag, " pe_instr"}, pe_instr, ins);
      exp_st = 2;
      finished = 1'b0;
      for (int w = 1; w <= TO && !finished; w++) begin
        @(negedge clk);
        pe_done = (w == done_lat);
        #1;
        check({tag, " start_pulse_once"}, 32'(pe_start), 32'd0);
        check({tag, " pe_abort"}, 32'(pe_abort), 32'((w == TO) && (done_lat != TO)));
        if (pe_done) begin
          exp_st = 0;
          finished = 1'b1;
        end else if (w == TO) begin
          finished = 1'b1;
        end
      end
      @(negedge clk);
      pe_done = 1'b0;
      #1;
      if (exp_st == 0 && cnt_m < 65535) cnt_m++;
    end else begin
      exp_st = 1;
    end
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_id"}, 32'(resp_id), 32'(g));
    check({tag, " resp_status"}, 32'(resp_status), 32'(exp_st));
    check({tag, " no_start_in_resp"}, 32'(pe_start), 32'd0);
    check({tag, " no_abort_in_resp"}, 32'(pe_abort), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      pe_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold_id"}, 32'(resp_id), 32'(g));
      check({tag, " hold_status"}, 32'(resp_status), 32'(exp_st));
      check({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    pe_done = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    rr_m = (g + 1) % N;
    check({tag, " back_to_idle"}, 32'(busy), 32'd0);
    check({tag, " done_count"}, 32'(done_count), 32'(cnt_m));
    $display("[TB] %s: grant=%0d instr=%08h status=%0d done_count=%0d",
             tag, g, ins, exp_st, cnt_m);
  endtask

  initial begin
    int r;
    int lat;
    // T1: reset with every requester asserting valid
    rst = 1'b1;
    req_valid = '1;
    pe_done = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) instr_m[i] = 32'h1000_0000;
    drive_instrs();
    @(posedge clk);
    @(negedge clk); #1;
    check("T1 req_ready", 32'(req_ready), 32'd0);
    check("T1 pe_start", 32'(pe_start), 32'd0);
    check("T1 pe_abort", 32'(pe_abort), 32'd0);
    check("T1 resp_valid", 32'(resp_valid), 32'd0);
    check("T1 resp_id", 32'(resp_id), 32'd0);
    check("T1 resp_status", 32'(resp_status), 32'd0);
    check("T1 busy", 32'(busy), 32'd0);
    check("T1 done_count", 32'(done_count), 32'd0);
    check("T1 pe_instr", pe_instr, 32'd0);
    @(negedge clk); #1;
    check("T1 req_ready_2nd", 32'(req_ready), 32'd0);
    $display("[TB] T1 reset checked");
    rst = 1'b0;

    // T2: single OK command from requester 0
    req_valid = 4'b0001;
    instr_m[0] = 32'h1000_0000;
    drive_instrs();
    run_cmd("T2", 12, 0);

    // T4: illegal opcode from requester 2
    req_valid = 4'b0100;
    instr_m[2] = 32'h7000_0000;
    drive_instrs();
    run_cmd("T4", 0, 0);

    // T5: timeout, then completion on the final budget cycle
    req_valid = 4'b0010;
    instr_m[1] = 32'h2000_0001;
    drive_instrs();
    run_cmd("T5a", 0, 0);
    run_cmd("T5b", TO, 0);

    // T6: response backpressure for 10 cycles
    req_valid = 4'b1000;
    instr_m[3] = 32'h3000_00AB;
    drive_instrs();
    run_cmd("T6a", 5, 10);

    // T6: reset during WAIT drops the command silently
    req_valid = 4'b0001;
    instr_m[0] = 32'h3000_0005;
    drive_instrs();
    #1;
    check("T6b req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    rr_m = 0;
    cnt_m = 0;
    check("T6b busy_after_rst", 32'(busy), 32'd0);
    check("T6b resp_after_rst", 32'(resp_valid), 32'd0);
    check("T6b abort_after_rst", 32'(pe_abort), 32'd0);
    check("T6b count_after_rst", 32'(done_count), 32'd0);
    check("T6b instr_after_rst", pe_instr, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("T6b no_late_resp", 32'(resp_valid), 32'd0);
    end
    $display("[TB] T6b reset mid-wait checked");

    // T6: stray pe_done in IDLE is ignored
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    #1;
    check("T6c busy", 32'(busy), 32'd0);
    check("T6c count", 32'(done_count), 32'd0);
    check("T6c resp", 32'(resp_valid), 32'd0);
    $display("[TB] T6c stray pe_done checked");

    // T3: all requesters valid continuously, order must be 0,1,2,3,0
    obs_log.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) instr_m[i] = {4'(1 + (i % 3)), 28'(i)};
    drive_instrs();
    for (int t = 0; t < 5; t++) run_cmd($sformatf("T3_%0d", t), 1 + t, 0);
    for (int t = 0; t < 5; t++) begin
      check($sformatf("T3 order%0d", t), 32'(obs_log[t]), 32'(t % N));
    end

    // Randomized commands with stray pe_done pulses while responses wait
    stray_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7) instr_m[i] = {4'($urandom_range(1, 3)), 28'($urandom)};
        else       instr_m[i] = {4'($urandom_range(0, 15)), 28'($urandom)};
      end
      drive_instrs();
      r = $urandom_range(0, 7);
      case (r)
        0:       lat = 0;
        1:       lat = TO;
        2:       lat = TO - 1;
        default: lat = $urandom_range(1, 15);
      endcase
      run_cmd($sformatf("R%0d", it), lat, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
